// File: rtl/mem_access_unit_if.sv
// Request/response bundle between the EX/MEM pipeline side and mem_access_unit.
// The pipeline side uses the master modport; the memory unit uses slave.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              MemRead;
    logic              MemWrite;
    logic [2:0]        Funct3;
    logic [ADDR_W-1:0] Addr;
    logic [31:0]       WriteData;
    logic              resp_valid;
    logic [31:0]       DataOut;
    logic              err;
    logic              busy;

    modport master (
        output req_valid, MemRead, MemWrite, Funct3, Addr, WriteData,
        input  req_ready, resp_valid, DataOut, err, busy
    );

    modport slave (
        input  req_valid, MemRead, MemWrite, Funct3, Addr, WriteData,
        output req_ready, resp_valid, DataOut, err, busy
    );
endinterface

// File: rtl/mem_access_unit.sv
// Data-memory stage: byte/half/word loads and stores on an internal word RAM,
// configurable load latency, valid/ready handshake and access error detection.
// Optional build macro MEM_PERF_EN adds saturating load/store/error counters.
module mem_access_unit #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 16384,
    parameter int RD_LATENCY  = 2
) (
    input  logic clk,
    input  logic rst,
    mem_access_unit_if.slave bus
`ifdef MEM_PERF_EN
    ,
    output logic [31:0] perf_loads,
    output logic [31:0] perf_stores,
    output logic [31:0] perf_errs
`endif
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [3:0]        lat_cnt;

    logic [31:0]       ram [DEPTH_WORDS];
    logic [31:0]       rd_word;

    logic              accept;
    logic [ADDR_W-1:0] word_addr;
    logic [IDX_W-1:0]  idx;
    logic              op_load;
    logic              op_store;
    logic              f3_ok_ld;
    logic              f3_ok_st;
    logic              misalign;
    logic              out_of_range;
    logic              req_err;
    logic [3:0]        be;
    logic [31:0]       wrep;

    logic              resp_err;
    logic              resp_load;
    logic              resp_store;
    logic [2:0]        ld_f3;
    logic [1:0]        ld_lane;
    logic [31:0]       data_hold;
    logic [31:0]       resp_data;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;

    assign accept    = bus.req_valid & bus.req_ready;
    assign word_addr = bus.Addr >> 2;
    assign idx       = word_addr[IDX_W-1:0];

    // Request decode: operation type, legality and alignment/range checks.
    always_comb begin
        op_load      = bus.MemRead & ~bus.MemWrite;
        op_store     = bus.MemWrite & ~bus.MemRead;
        f3_ok_ld     = bus.Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        f3_ok_st     = bus.Funct3 inside {3'b000, 3'b001, 3'b010};
        misalign     = 1'b0;
        case (bus.Funct3[1:0])
            2'b01:   misalign = bus.Addr[0];
            2'b10:   misalign = |bus.Addr[1:0];
            default: misalign = 1'b0;
        endcase
        out_of_range = (word_addr >= ADDR_W'(DEPTH_WORDS));
        req_err      = (bus.MemRead & bus.MemWrite)
                     | (op_load  & (~f3_ok_ld | misalign | out_of_range))
                     | (op_store & (~f3_ok_st | misalign | out_of_range));
    end

    // Store byte enables and lane-replicated write data (little-endian).
    always_comb begin
        be   = 4'b1111;
        wrep = bus.WriteData;
        case (bus.Funct3[1:0])
            2'b00: begin
                be   = 4'b0001 << bus.Addr[1:0];
                wrep = {4{bus.WriteData[7:0]}};
            end
            2'b01: begin
                be   = bus.Addr[1] ? 4'b1100 : 4'b0011;
                wrep = {2{bus.WriteData[15:0]}};
            end
            default: begin
                be   = 4'b1111;
                wrep = bus.WriteData;
            end
        endcase
    end

    // RAM: stores land at their accept edge; loads capture the word at accept.
    always_ff @(posedge clk) begin
        if (accept && op_store && !req_err) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) begin
                    ram[idx][b*8 +: 8] <= wrep[b*8 +: 8];
                end
            end
        end
        if (accept && op_load && !req_err) begin
            rd_word <= ram[idx];
        end
    end

    // State register plus per-request response context and held output data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            resp_err   <= 1'b0;
            resp_load  <= 1'b0;
            resp_store <= 1'b0;
            ld_f3      <= '0;
            ld_lane    <= '0;
            data_hold  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                resp_err   <= req_err;
                resp_load  <= op_load & ~req_err;
                resp_store <= op_store & ~req_err;
                ld_f3      <= bus.Funct3;
                ld_lane    <= bus.Addr[1:0];
                lat_cnt    <= 4'(RD_LATENCY - 1);
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
            if (state == RESP) begin
                data_hold <= resp_data;
            end
        end
    end

    // Next-state: accepts happen in IDLE or RESP; WAIT counts down the load latency.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    state_nx = (op_load && !req_err && RD_LATENCY > 1) ? WAIT : RESP;
                end else begin
                    state_nx = IDLE;
                end
            end
            WAIT: begin
                if (lat_cnt <= 4'd1) begin
                    state_nx = RESP;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Load lane selection and sign/zero extension.
    always_comb begin
        lane_b    = rd_word[{ld_lane, 3'b000} +: 8];
        lane_h    = ld_lane[1] ? rd_word[31:16] : rd_word[15:0];
        resp_data = '0;
        if (resp_load) begin
            case (ld_f3)
                3'b000:  resp_data = {{24{lane_b[7]}}, lane_b};
                3'b100:  resp_data = {24'b0, lane_b};
                3'b001:  resp_data = {{16{lane_h[15]}}, lane_h};
                3'b101:  resp_data = {16'b0, lane_h};
                default: resp_data = rd_word;
            endcase
        end
    end

    // Handshake and response outputs; DataOut holds between responses.
    always_comb begin
        bus.req_ready  = (state != WAIT);
        bus.busy       = (state == WAIT);
        bus.resp_valid = (state == RESP);
        bus.err        = (state == RESP) & resp_err;
        bus.DataOut    = (state == RESP) ? resp_data : data_hold;
    end

`ifdef MEM_PERF_EN
    // Saturating per-response event counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_loads  <= '0;
            perf_stores <= '0;
            perf_errs   <= '0;
        end else if (state == RESP) begin
            if (resp_load && !(&perf_loads)) begin
                perf_loads <= perf_loads + 32'd1;
            end
            if (resp_store && !(&perf_stores)) begin
                perf_stores <= perf_stores + 32'd1;
            end
            if (resp_err && !(&perf_errs)) begin
                perf_errs <= perf_errs + 32'd1;
            end
        end
    end
`endif

endmodule
